ovl_win_check_mc: RTL and testbench

OVL_WIN_CHECK_MC -- requirements
Module: ovl_win_check_mc

---
 rtl/ovl_win_check_mc.sv | 134 +++++++++++++
 tb/tb_ovl_win_check_mc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ovl_win_check_mc.sv
// Multi-channel window checker: each channel watches its slice of test_expr between start/end events.
// Latency: fire/err_code are registered one cycle after the deciding sample; viol_count follows fire by one cycle.
// Backpressure: none; enable=0 freezes every channel in place.
module ovl_win_check_mc #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int MODE     = 0,
  parameter int MAX_WIN  = 8,
  parameter int CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       start_event,
  input  logic [CHANNELS-1:0]       end_event,
  input  logic [CHANNELS*WIDTH-1:0] test_expr,
  output logic [CHANNELS-1:0]       fire,
  output logic [2*CHANNELS-1:0]     err_code,
  output logic [CHANNELS-1:0]       win_open,
  output logic [CNT_W-1:0]          viol_count
);

  localparam int TMR_W = (MAX_WIN > 0) ? $clog2(MAX_WIN + 1) : 1;
  localparam int PW    = $clog2(CHANNELS + 1);
  localparam int SUM_W = CNT_W + PW;

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

  logic [CHANNELS-1:0]   fire_nxt;
  logic [2*CHANNELS-1:0] err_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               chg_q, chg_d;
    logic [WIDTH-1:0]   sample;
    logic               mismatch;
    logic [TMR_W-1:0]   tmr_inc;
    logic               tmo;
    logic               fire_c;
    logic [1:0]         err_c;

    assign sample   = test_expr[i*WIDTH +: WIDTH];
    assign mismatch = (sample != ref_q);
    assign tmr_inc  = tmr_q + 1'b1;
    assign tmo      = (MAX_WIN > 0) && (tmr_inc == TMR_W'(MAX_WIN));

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        ref_q   <= '0;
        tmr_q   <= '0;
        chg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ref_q   <= ref_d;
        tmr_q   <= tmr_d;
        chg_q   <= chg_d;
      end
    end

    // Priority inside an open window: value violation, then close, then timeout.
    always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      tmr_d   = tmr_q;
      chg_d   = chg_q;
      fire_c  = 1'b0;
      err_c   = 2'b00;
      case (state_q)
        IDLE: begin
          if (enable && start_event[i]) begin
            ref_d   = sample;
            tmr_d   = '0;
            chg_d   = 1'b0;
            state_d = OPEN;
          end
        end
        OPEN: begin
          if (enable) begin
            if (MODE == 0 && mismatch) begin
              fire_c  = 1'b1;
              err_c   = 2'b01;
              state_d = IDLE;
            end else if (end_event[i]) begin
              if (MODE != 0 && !(chg_q || mismatch)) begin
                fire_c = 1'b1;
                err_c  = 2'b11;
              end
              state_d = IDLE;
            end else if (tmo) begin
              fire_c  = 1'b1;
              err_c   = 2'b10;
              state_d = IDLE;
            end else begin
              tmr_d = (MAX_WIN > 0) ? tmr_inc : tmr_q;
              chg_d = chg_q | mismatch;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign fire_nxt[i]        = fire_c;
    assign err_nxt[2*i +: 2]  = err_c;
    assign win_open[i]        = (state_q == OPEN);
  end

  logic [PW-1:0]    pop;
  logic [SUM_W-1:0] sum;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

  always_comb begin
    pop = '0;
    for (int k = 0; k < CHANNELS; k++) pop = pop + PW'(fire[k]);
  end

  assign sum = SUM_W'(viol_count) + SUM_W'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      fire       <= '0;
      err_code   <= '0;
      viol_count <= '0;
    end else begin
      fire       <= fire_nxt;
      err_code   <= err_nxt;
      viol_count <= (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_ovl_win_check_mc.sv
// Scoreboard bench for ovl_win_check_mc: a MODE 0 instance and a MODE 1 instance with a 2-bit counter.
module tb_ovl_win_check_mc;
  logic       clock = 1'b0;
  logic       reset, enable;
  logic [1:0] start_a, end_a, start_b, end_b;
  logic [7:0] expr_a, expr_b;
  logic [1:0] fire_a, fire_b, wo_a, wo_b;
  logic [3:0] err_a, err_b;
  logic [7:0] vc_a;
  logic [1:0] vc_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {int cyc; logic [1:0] fire; logic [3:0] err;} exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t xa, xb;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ovl_win_check_mc #(.WIDTH(4), .CHANNELS(2), .MODE(0), .MAX_WIN(8), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .start_event(start_a), .end_event(end_a),
    .test_expr(expr_a), .fire(fire_a), .err_code(err_a), .win_open(wo_a), .viol_count(vc_a));

  ovl_win_check_mc #(.WIDTH(4), .CHANNELS(2), .MODE(1), .MAX_WIN(8), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .start_event(start_b), .end_event(end_b),
    .test_expr(expr_b), .fire(fire_b), .err_code(err_b), .win_open(wo_b), .viol_count(vc_b));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Expected fire lands dly edges after the current one.
  task automatic push_a(input int dly, input logic [1:0] f, input logic [3:0] e);
    exp_t x;
    x.cyc = cyc + dly; x.fire = f; x.err = e;
    q_a.push_back(x);
  endtask

  task automatic push_b(input int dly, input logic [1:0] f, input logic [3:0] e);
    exp_t x;
    x.cyc = cyc + dly; x.fire = f; x.err = e;
    q_b.push_back(x);
  endtask

  always @(negedge clock) begin
    if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      xa = q_a.pop_front();
      chk("fire_a", fire_a, xa.fire);
      chk("err_a", err_a, xa.err);
      chk("fire_cyc_a", cyc, xa.cyc);
    end else if (fire_a != 2'b00) begin
      chk("unexp_fire_a", fire_a, 0);
    end else if (err_a != 4'b0000) begin
      chk("err_idle_a", err_a, 0);
    end
    if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      xb = q_b.pop_front();
      chk("fire_b", fire_b, xb.fire);
      chk("err_b", err_b, xb.err);
      chk("fire_cyc_b", cyc, xb.cyc);
    end else if (fire_b != 2'b00) begin
      chk("unexp_fire_b", fire_b, 0);
    end else if (err_b != 4'b0000) begin
      chk("err_idle_b", err_b, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    start_a = 2'b11; end_a = 2'b00; start_b = 2'b11; end_b = 2'b00;
    expr_a = 8'h00; expr_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      expr_a = ~expr_a; expr_b = ~expr_b;
      step(1);
    end
    chk("rst_fire", fire_a, 0);
    chk("rst_wo", wo_a, 0);
    chk("rst_vc", vc_a, 0);
    chk("rst_wo_b", wo_b, 0);

    reset = 1'b0; start_a = 2'b00; start_b = 2'b00; expr_a = 8'h00; expr_b = 8'h33;
    step(1);

    // value change one cycle after start
    expr_a = 8'h0A; start_a = 2'b01; step(1);
    chk("t1_wo_open", wo_a, 2'b01);
    start_a = 2'b00; expr_a = 8'h09; push_a(1, 2'b01, 4'b0001); step(1);
    step(1);
    chk("t1_vc", vc_a, 1);
    chk("t1_wo_closed", wo_a, 0);

    // held value, clean close
    expr_a = 8'h0A; start_a = 2'b01; step(1);
    start_a = 2'b00; step(3);
    chk("t2_wo_open", wo_a, 2'b01);
    end_a = 2'b01; step(1);
    end_a = 2'b00;
    chk("t2_wo_closed", wo_a, 0);
    step(1);
    chk("t2_vc", vc_a, 1);

    // ch1 timeout after 8 enabled open cycles
    expr_a = 8'h50; start_a = 2'b10; step(1);
    start_a = 2'b00; push_a(8, 2'b10, 4'b1000);
    step(7);
    chk("t3_wo_before_tmo", wo_a, 2'b10);
    step(1);
    chk("t3_wo_after_tmo", wo_a, 0);
    step(1);
    chk("t3_vc", vc_a, 2);

    // same timeout stretched by two disabled cycles with garbage data
    start_a = 2'b10; step(1);
    start_a = 2'b00; step(3);
    enable = 1'b0; expr_a = 8'hF0; step(2);
    chk("t3b_wo_frozen", wo_a, 2'b10);
    enable = 1'b1; expr_a = 8'h50; push_a(5, 2'b10, 4'b1000); step(5);
    step(1);
    chk("t3b_vc", vc_a, 3);

    // both channels violate together; ch0 also sees end_event (violation wins)
    expr_a = 8'h00; start_a = 2'b11; step(1);
    start_a = 2'b00; end_a = 2'b01; expr_a = 8'h1F; push_a(1, 2'b11, 4'b0101); step(1);
    end_a = 2'b00; expr_a = 8'h00; step(1);
    chk("t4_vc", vc_a, 5);
    chk("t4_wo", wo_a, 0);

    // MODE 1: no change seen before end
    expr_b = 8'h03; start_b = 2'b01; step(1);
    start_b = 2'b00; step(1);
    end_b = 2'b01; push_b(1, 2'b01, 4'b0011); step(1);
    end_b = 2'b00; step(1);
    chk("m1_vc", vc_b, 1);
    chk("m1_wo", wo_b, 0);

    // MODE 1: one change mid-window, then end
    start_b = 2'b01; step(1);
    start_b = 2'b00; expr_b = 8'h07; step(1);
    expr_b = 8'h03; end_b = 2'b01; step(1);
    end_b = 2'b00; step(1);
    chk("m1_chg_vc", vc_b, 1);

    // MODE 1: change on the end cycle itself
    start_b = 2'b01; step(1);
    start_b = 2'b00; step(1);
    expr_b = 8'h0B; end_b = 2'b01; step(1);
    end_b = 2'b00; expr_b = 8'h03; step(1);
    chk("m1_endchg_vc", vc_b, 1);

    // MODE 1: paired fires drive the 2-bit counter into saturation
    expr_b = 8'h33;
    for (int i = 0; i < 3; i++) begin
      start_b = 2'b11; step(1);
      start_b = 2'b00; end_b = 2'b11; push_b(1, 2'b11, 4'b1111); step(1);
      end_b = 2'b00; step(1);
      chk("m1_sat_vc", vc_b, 3);
    end

    // reset mid-window while the value changes
    expr_a = 8'h0A; start_a = 2'b01; step(1);
    start_a = 2'b00; step(1);
    reset = 1'b1; expr_a = 8'h05; step(1);
    chk("t5_wo", wo_a, 0);
    chk("t5_vc", vc_a, 0);
    chk("t5_fire", fire_a, 0);
    chk("t5_vc_b", vc_b, 0);
    expr_a = 8'h0A; step(1);
    reset = 1'b0; step(2);
    chk("t5_fire_after", fire_a, 0);
    chk("t5_wo_after", wo_a, 0);

    chk("q_a_left", q_a.size(), 0);
    chk("q_b_left", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
